// File: rtl/midi_pkg.sv
// midi_pkg
//   Shared constants and helpers for the MIDI receive path.
//   MIDI_BAUD_CLKS : default clk cycles per UART bit (100 MHz / 31250 baud)
//   STATUS_MIN     : lowest channel status byte
//   SYSCOM_MIN     : lowest system common / SysEx byte
//   REALTIME_MIN   : lowest system realtime byte
//   midi_data_len  : number of data bytes that follow a channel status byte
package midi_pkg;

    localparam int MIDI_BAUD_CLKS = 3200;

    localparam logic [7:0] STATUS_MIN   = 8'h80;
    localparam logic [7:0] SYSCOM_MIN   = 8'hF0;
    localparam logic [7:0] REALTIME_MIN = 8'hF8;

    // Program change (0xCn) and channel pressure (0xDn) carry a single data
    // byte, every other channel message carries two. Anything that is not a
    // channel status byte has no data of its own as far as the parser cares.
    function automatic logic [1:0] midi_data_len(input logic [7:0] status);
        logic [1:0] len;
        len = 2'd0;
        if (status >= STATUS_MIN && status < SYSCOM_MIN) begin
            if (status[7:4] == 4'hC || status[7:4] == 4'hD) begin
                len = 2'd1;
            end else begin
                len = 2'd2;
            end
        end
        return len;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte
//   8N1 UART receiver: two-flop synchroniser on rx followed by a start /
//   data / stop state machine sampling in the middle of each bit.
//   clk         : system clock
//   rst_n       : asynchronous active-low reset
//   rx          : raw serial input, idle high, asynchronous to clk
//   byte_valid  : 1-cycle pulse, byte_data holds a correctly framed byte
//   byte_data   : last correctly framed byte, held until the next one
//   framing_err : 1-cycle pulse, stop bit sampled low and the byte dropped
module uart_rx_byte
    import midi_pkg::*;
#(
    parameter int CLKS_PER_BIT = MIDI_BAUD_CLKS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       framing_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    rx_state_t     state;
    logic          rx_meta;
    logic          rx_s;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;

    // The synchroniser resets to the idle level so that reset release is not
    // mistaken for a start bit. Everything downstream only looks at rx_s.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Frame state machine. The start bit is re-checked half a bit after the
    // falling edge so short glitches are rejected; from there on every sample
    // lands one full bit later, i.e. in the middle of each data and stop bit.
    // A low stop bit parks the machine in BREAK until the line returns high,
    // so a held-low line or break condition produces only one error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            byte_valid  <= 1'b0;
            byte_data   <= '0;
            framing_err <= 1'b0;
        end else begin
            byte_valid  <= 1'b0;
            framing_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state    <= START;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                    end
                end
                START: begin
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= '0;
                        state    <= rx_s ? IDLE : DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= '0;
                        shift    <= {rx_s, shift[7:1]};
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= '0;
                        if (rx_s) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shift;
                            state      <= IDLE;
                        end else begin
                            framing_err <= 1'b1;
                            state       <= BREAK;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/midi_uart_rx.sv
// midi_uart_rx
//   MIDI receiver: UART byte deserialiser plus a message parser with running
//   status and transparent handling of interleaved realtime bytes.
//   clk         : system clock (100 MHz)
//   rst_n       : asynchronous active-low reset
//   rx          : raw serial input, idle high
//   byte_valid  : 1-cycle pulse, byte_data holds a framed byte
//   byte_data   : last received byte
//   framing_err : 1-cycle pulse, byte dropped because of a low stop bit
//   msg_valid   : 1-cycle pulse, msg_* hold a complete message
//   msg_status  : status byte of the message (running status applied)
//   msg_data1   : first data byte, 0 if none
//   msg_data2   : second data byte, 0 if none
module midi_uart_rx
    import midi_pkg::*;
#(
    parameter int CLKS_PER_BIT = MIDI_BAUD_CLKS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       framing_err,
    output logic       msg_valid,
    output logic [7:0] msg_status,
    output logic [6:0] msg_data1,
    output logic [6:0] msg_data2
);

    logic [7:0] run_status;
    logic       data_cnt;
    logic [6:0] pend_data1;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .framing_err(framing_err)
    );

    // Message parser, advanced once per received byte. A run_status of zero
    // means "no running status" since every real status byte has bit 7 set.
    // Realtime bytes are reported immediately and leave the running status
    // and any half-collected message alone, so they can sit between the data
    // bytes of another message. System common / SysEx clears running status,
    // which makes the following data bytes fall into the discard path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_status <= '0;
            data_cnt   <= 1'b0;
            pend_data1 <= '0;
            msg_valid  <= 1'b0;
            msg_status <= '0;
            msg_data1  <= '0;
            msg_data2  <= '0;
        end else begin
            msg_valid <= 1'b0;
            if (byte_valid) begin
                if (byte_data >= REALTIME_MIN) begin
                    msg_valid  <= 1'b1;
                    msg_status <= byte_data;
                    msg_data1  <= '0;
                    msg_data2  <= '0;
                end else if (byte_data >= SYSCOM_MIN) begin
                    run_status <= '0;
                    data_cnt   <= 1'b0;
                end else if (byte_data >= STATUS_MIN) begin
                    run_status <= byte_data;
                    data_cnt   <= 1'b0;
                end else if (run_status != 8'h00) begin
                    if (!data_cnt) begin
                        if (midi_data_len(run_status) == 2'd1) begin
                            msg_valid  <= 1'b1;
                            msg_status <= run_status;
                            msg_data1  <= byte_data[6:0];
                            msg_data2  <= '0;
                        end else begin
                            pend_data1 <= byte_data[6:0];
                            data_cnt   <= 1'b1;
                        end
                    end else begin
                        msg_valid  <= 1'b1;
                        msg_status <= run_status;
                        msg_data1  <= pend_data1;
                        msg_data2  <= byte_data[6:0];
                        data_cnt   <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_midi_uart_rx.sv
// tb_midi_uart_rx
//   Directed self-checking bench for midi_uart_rx with a short bit period.
//   Drives 8N1 frames on rx, counts output pulses and logs every message,
//   then compares against hand-computed expectations.
module tb_midi_uart_rx;

    localparam int CPB = 16;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       framing_err;
    logic       msg_valid;
    logic [7:0] msg_status;
    logic [6:0] msg_data1;
    logic [6:0] msg_data2;

    int total;
    int bad;
    int bv_cnt;
    int fe_cnt;
    int mv_cnt;
    logic [23:0] msg_q[$];

    int bv_base;
    int fe_base;
    int mv_base;
    int q_base;

    midi_uart_rx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .framing_err(framing_err),
        .msg_valid  (msg_valid),
        .msg_status (msg_status),
        .msg_data1  (msg_data1),
        .msg_data2  (msg_data2)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor on the falling edge, away from the edge the DUT updates on.
    // Pulses are counted cumulatively and each message is logged packed as
    // {status, 0, data1, 0, data2} so it reads naturally in hex.
    initial begin
        bv_cnt = 0;
        fe_cnt = 0;
        mv_cnt = 0;
    end

    always @(negedge clk) begin
        if (byte_valid) bv_cnt = bv_cnt + 1;
        if (framing_err) fe_cnt = fe_cnt + 1;
        if (msg_valid) begin
            mv_cnt = mv_cnt + 1;
            msg_q.push_back({msg_status, 1'b0, msg_data1, 1'b0, msg_data2});
        end
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        total = total + 1;
        if (actual !== expected) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Logged message by index, or a value no 24-bit message can take.
    function automatic logic [31:0] getMsg(input int idx);
        if (idx < msg_q.size()) begin
            return {8'h00, msg_q[idx]};
        end
        return 32'hFFFF_FFFF;
    endfunction

    // Drive the first nbits of an 8N1 frame (start, 8 data LSB first, stop).
    // rx is left at the last driven bit level.
    task automatic applyStimulus(input logic [7:0] value, input logic stop_level,
                                 input int nbits);
        logic [9:0] frame;
        frame = {stop_level, value, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            rx = frame[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic idleLine(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic sendByte(input logic [7:0] value);
        applyStimulus(value, 1'b1, 10);
        idleLine(8);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic markBase();
        bv_base = bv_cnt;
        fe_base = fe_cnt;
        mv_base = mv_cnt;
        q_base  = msg_q.size();
    endtask

    // Directed scenarios; each one snapshots the counters and checks deltas.
    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);

        checkOutput("reset_byte_data", 32'(byte_data), 32'h0);
        checkOutput("reset_pulses", 32'({byte_valid, framing_err, msg_valid}), 32'h0);
        checkOutput("reset_msg", 32'({msg_status, msg_data1, msg_data2}), 32'h0);

        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] note on");
        markBase();
        sendByte(8'h90);
        sendByte(8'h3C);
        sendByte(8'h64);
        checkOutput("t1_byte_cnt", 32'(bv_cnt - bv_base), 32'd3);
        checkOutput("t1_msg_cnt", 32'(mv_cnt - mv_base), 32'd1);
        checkOutput("t1_msg", getMsg(q_base), 32'h903C64);
        checkOutput("t1_byte_data", 32'(byte_data), 32'h64);

        $display("[TB] running status");
        markBase();
        sendByte(8'h90);
        sendByte(8'h3C);
        sendByte(8'h64);
        sendByte(8'h3C);
        sendByte(8'h00);
        checkOutput("t2_msg_cnt", 32'(mv_cnt - mv_base), 32'd2);
        checkOutput("t2_msg0", getMsg(q_base), 32'h903C64);
        checkOutput("t2_msg1", getMsg(q_base + 1), 32'h903C00);

        $display("[TB] realtime interleave");
        markBase();
        sendByte(8'h90);
        sendByte(8'hF8);
        sendByte(8'h3C);
        sendByte(8'h64);
        checkOutput("t3_msg_cnt", 32'(mv_cnt - mv_base), 32'd2);
        checkOutput("t3_msg0", getMsg(q_base), 32'hF80000);
        checkOutput("t3_msg1", getMsg(q_base + 1), 32'h903C64);

        $display("[TB] program change and orphan data");
        markBase();
        sendByte(8'hC5);
        sendByte(8'h07);
        checkOutput("t4_msg_cnt", 32'(mv_cnt - mv_base), 32'd1);
        checkOutput("t4_msg", getMsg(q_base), 32'hC50700);
        doReset();
        markBase();
        sendByte(8'h3C);
        sendByte(8'h64);
        checkOutput("t4_orphan_bytes", 32'(bv_cnt - bv_base), 32'd2);
        checkOutput("t4_orphan_msgs", 32'(mv_cnt - mv_base), 32'd0);

        $display("[TB] framing error");
        doReset();
        markBase();
        applyStimulus(8'h3C, 1'b0, 10);
        rx = 1'b0;
        repeat (40) @(negedge clk);
        idleLine(8);
        checkOutput("t5_framing_cnt", 32'(fe_cnt - fe_base), 32'd1);
        checkOutput("t5_bad_byte_cnt", 32'(bv_cnt - bv_base), 32'd0);
        sendByte(8'h45);
        checkOutput("t5_byte_cnt", 32'(bv_cnt - bv_base), 32'd1);
        checkOutput("t5_byte_data", 32'(byte_data), 32'h45);
        checkOutput("t5_framing_after", 32'(fe_cnt - fe_base), 32'd1);
        checkOutput("t5_msg_cnt", 32'(mv_cnt - mv_base), 32'd0);

        $display("[TB] glitch and reset");
        markBase();
        rx = 1'b0;
        repeat (4) @(negedge clk);
        idleLine(200);
        checkOutput("t6_glitch_pulses", 32'((bv_cnt - bv_base) + (fe_cnt - fe_base)), 32'd0);
        sendByte(8'h90);
        sendByte(8'h3C);
        sendByte(8'h64);
        checkOutput("t6_pre_msg", getMsg(q_base), 32'h903C64);
        markBase();
        applyStimulus(8'h90, 1'b1, 4);
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("t6_rst_byte_data", 32'(byte_data), 32'h0);
        checkOutput("t6_rst_pulses", 32'({byte_valid, framing_err, msg_valid}), 32'h0);
        checkOutput("t6_rst_msg", 32'({msg_status, msg_data1, msg_data2}), 32'h0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idleLine(200);
        checkOutput("t6_after_bytes", 32'(bv_cnt - bv_base), 32'd0);
        checkOutput("t6_after_msgs", 32'(mv_cnt - mv_base), 32'd0);
        sendByte(8'h3C);
        sendByte(8'h64);
        checkOutput("t6_data_bytes", 32'(bv_cnt - bv_base), 32'd2);
        checkOutput("t6_data_msgs", 32'(mv_cnt - mv_base), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
